mem_share_control_wrapper: RTL and testbench



---
 rtl/mem_share_control_wrapper.sv | 135 +++++++++++++
 tb/tb_mem_share_control_wrapper.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mem_share_control_wrapper.sv
// Memory-share scheduling control for one share group.
// Holds the L1PA shift-pattern register file and steps through 1-, 2- or
// 4-page shift sequences, one page per clock, starting at the lane0 address.
//
// state | meaning
// READY | no sequence running (cnt=0); a non-idle mode starts a new sequence
// BUSY  | sequence in progress (cnt!=0); request inputs are ignored
module mem_share_control_wrapper #(
  parameter int SHARE_GROUP_SIZE        = 5,
  parameter int RQST_ADDR_BITWIDTH      = 3,
  parameter int RQST_MODE_BITWIDTH      = 2,
  parameter int L1PA_REGFILE_PAGE_NUM   = 8,
  parameter int L1PA_REGFILE_ADDR_WIDTH = $clog2(L1PA_REGFILE_PAGE_NUM),
  parameter int L1PA_REGFILE_PAGE_WIDTH = $clog2(SHARE_GROUP_SIZE)
) (
  input  logic                                         sys_clk,
  input  logic                                         rstn,
  input  logic [RQST_ADDR_BITWIDTH*SHARE_GROUP_SIZE-1:0] rqst_addr_i,
  input  logic [RQST_MODE_BITWIDTH-1:0]                modeSet_i,
  output logic [$clog2(SHARE_GROUP_SIZE)-1:0]          l1pa_shift_o,
  output logic                                         isGtr_o,
  input  logic [L1PA_REGFILE_ADDR_WIDTH-1:0]           regType0_waddr_i,
  input  logic [L1PA_REGFILE_PAGE_WIDTH-1:0]           regType0_wdata_i,
  input  logic                                         regType0_we_i
);

  localparam int AW = L1PA_REGFILE_ADDR_WIDTH;
  localparam int PW = L1PA_REGFILE_PAGE_WIDTH;
  localparam int SW = $clog2(SHARE_GROUP_SIZE);

  localparam logic [RQST_MODE_BITWIDTH-1:0] MODE_IDLE = RQST_MODE_BITWIDTH'(0);
  localparam logic [RQST_MODE_BITWIDTH-1:0] MODE_1SEQ = RQST_MODE_BITWIDTH'(1);
  localparam logic [RQST_MODE_BITWIDTH-1:0] MODE_2SEQ = RQST_MODE_BITWIDTH'(2);

  typedef enum logic {READY, BUSY} seqState_t;

  seqState_t       stateQ, stateNext;
  logic [1:0]      cntQ, cntNext;
  logic [1:0]      kQ, kNext;
  logic [AW-1:0]   baseQ, baseNext;
  logic [SW-1:0]   shiftNext;
  logic            isGtrNext;
  logic [PW-1:0]   rf [L1PA_REGFILE_PAGE_NUM];
  logic [AW-1:0]   laneBase;
  logic [AW-1:0]   stepAddr;

  // Only lane0 carries an address in this revision; the other lanes are ignored.
  logic unusedLanes;
  assign unusedLanes = ^rqst_addr_i[RQST_ADDR_BITWIDTH*SHARE_GROUP_SIZE-1:RQST_ADDR_BITWIDTH];

  generate
    if (RQST_ADDR_BITWIDTH >= AW) begin : gBaseTrunc
      assign laneBase = rqst_addr_i[AW-1:0];
      if (RQST_ADDR_BITWIDTH > AW) begin : gUnusedHigh
        logic unusedLane0High;
        assign unusedLane0High = ^rqst_addr_i[RQST_ADDR_BITWIDTH-1:AW];
      end
    end else begin : gBaseExt
      assign laneBase = {{(AW-RQST_ADDR_BITWIDTH){1'b0}}, rqst_addr_i[RQST_ADDR_BITWIDTH-1:0]};
    end
  endgenerate

  // Page address wraps naturally through the power-of-two address width.
  assign stepAddr = baseQ + AW'(kQ);

  // Register file: synchronous write; reads elsewhere see the pre-edge contents.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < L1PA_REGFILE_PAGE_NUM; i++) rf[i] <= '0;
    end else if (regType0_we_i) begin
      rf[regType0_waddr_i] <= regType0_wdata_i;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      stateQ       <= READY;
      cntQ         <= '0;
      kQ           <= '0;
      baseQ        <= '0;
      l1pa_shift_o <= '0;
      isGtr_o      <= 1'b0;
    end else begin
      stateQ       <= stateNext;
      cntQ         <= cntNext;
      kQ           <= kNext;
      baseQ        <= baseNext;
      l1pa_shift_o <= shiftNext;
      isGtr_o      <= isGtrNext;
    end
  end

  // Next-state and output decode; cnt holds the steps still to issue.
  always_comb begin
    stateNext = stateQ;
    cntNext   = cntQ;
    kNext     = kQ;
    baseNext  = baseQ;
    shiftNext = '0;
    isGtrNext = 1'b0;
    case (stateQ)
      READY: begin
        if (modeSet_i != MODE_IDLE) begin
          baseNext  = laneBase;
          shiftNext = SW'(rf[laneBase]);
          kNext     = 2'd1;
          if (modeSet_i == MODE_1SEQ) begin
            cntNext   = 2'd0;
            isGtrNext = 1'b1;
            stateNext = READY;
          end else if (modeSet_i == MODE_2SEQ) begin
            cntNext   = 2'd1;
            stateNext = BUSY;
          end else begin
            cntNext   = 2'd3;
            stateNext = BUSY;
          end
        end
      end
      BUSY: begin
        shiftNext = SW'(rf[stepAddr]);
        isGtrNext = (cntQ == 2'd1);
        cntNext   = cntQ - 2'd1;
        kNext     = kQ + 2'd1;
        if (cntQ == 2'd1) stateNext = READY;
      end
      default: begin
        stateNext = READY;
        cntNext   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_share_control_wrapper.sv
// Directed bench for mem_share_control_wrapper: a vector table for the main
// sequences plus a hand-written async-reset abort sequence.
module tb_mem_share_control_wrapper;

  logic        sys_clk;
  logic        rstn;
  logic [14:0] rqst_addr_i;
  logic [1:0]  modeSet_i;
  logic [2:0]  l1pa_shift_o;
  logic        isGtr_o;
  logic [2:0]  regType0_waddr_i;
  logic [2:0]  regType0_wdata_i;
  logic        regType0_we_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       we;
    logic [2:0] waddr;
    logic [2:0] wdata;
    logic [1:0] mode;
    logic [2:0] addr;
    logic [2:0] expShift;
    logic       expGtr;
  } vec_t;

  vec_t vecs [32];
  int   nVec = 0;

  mem_share_control_wrapper dut (
    .sys_clk          (sys_clk),
    .rstn             (rstn),
    .rqst_addr_i      (rqst_addr_i),
    .modeSet_i        (modeSet_i),
    .l1pa_shift_o     (l1pa_shift_o),
    .isGtr_o          (isGtr_o),
    .regType0_waddr_i (regType0_waddr_i),
    .regType0_wdata_i (regType0_wdata_i),
    .regType0_we_i    (regType0_we_i)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic addVec(input logic we, input logic [2:0] waddr, input logic [2:0] wdata,
                        input logic [1:0] mode, input logic [2:0] addr,
                        input logic [2:0] expShift, input logic expGtr);
    vecs[nVec] = '{we, waddr, wdata, mode, addr, expShift, expGtr};
    nVec++;
  endtask

  task automatic check(input string name, input logic [2:0] expShift, input logic expGtr);
    checks++;
    if (l1pa_shift_o !== expShift || isGtr_o !== expGtr) begin
      errors++;
      $display("FAIL %s: got shift=%0d isGtr=%0b, want shift=%0d isGtr=%0b",
               name, l1pa_shift_o, isGtr_o, expShift, expGtr);
    end
  endtask

  // Upper lanes carry junk to show they are ignored.
  task automatic drive(input logic we, input logic [2:0] waddr, input logic [2:0] wdata,
                       input logic [1:0] mode, input logic [2:0] addr);
    regType0_we_i    = we;
    regType0_waddr_i = waddr;
    regType0_wdata_i = wdata;
    modeSet_i        = mode;
    rqst_addr_i      = {12'hA5C, addr};
  endtask

  task automatic stepCheck(input string name, input logic [2:0] expShift, input logic expGtr);
    @(posedge sys_clk);
    #1;
    check(name, expShift, expGtr);
  endtask

  initial begin
    // T1: load RF[i]=i with mode idle
    for (int i = 0; i < 8; i++) addVec(1'b1, 3'(i), 3'(i), 2'd0, 3'd0, 3'd0, 1'b0);
    // T2: single step then idle
    addVec(1'b0, 3'd0, 3'd0, 2'd1, 3'd2, 3'd2, 1'b1);
    addVec(1'b0, 3'd0, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0);
    // T3: 2SEQ, lane0 change during second step ignored
    addVec(1'b0, 3'd0, 3'd0, 2'd2, 3'd3, 3'd3, 1'b0);
    addVec(1'b0, 3'd0, 3'd0, 2'd2, 3'd7, 3'd4, 1'b1);
    addVec(1'b0, 3'd0, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0);
    // T4: 4SEQ with wrap, mode idle while busy, then back-to-back 1SEQ
    addVec(1'b0, 3'd0, 3'd0, 2'd3, 3'd6, 3'd6, 1'b0);
    addVec(1'b0, 3'd0, 3'd0, 2'd3, 3'd6, 3'd7, 1'b0);
    addVec(1'b0, 3'd0, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0);
    addVec(1'b0, 3'd0, 3'd0, 2'd0, 3'd0, 3'd1, 1'b1);
    addVec(1'b0, 3'd0, 3'd0, 2'd1, 3'd5, 3'd5, 1'b1);
    addVec(1'b0, 3'd0, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0);
    // T5: read-before-write on page 4, then the new value
    addVec(1'b1, 3'd4, 3'd7, 2'd1, 3'd4, 3'd4, 1'b1);
    addVec(1'b0, 3'd0, 3'd0, 2'd1, 3'd4, 3'd7, 1'b1);
    addVec(1'b0, 3'd0, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0);

    rstn = 1'b0;
    drive(1'b0, 3'd0, 3'd0, 2'd0, 3'd0);
    #1;
    check("reset_async", 3'd0, 1'b0);
    repeat (10) @(posedge sys_clk);
    #1;
    check("reset_hold", 3'd0, 1'b0);
    @(negedge sys_clk);
    rstn = 1'b1;

    for (int v = 0; v < nVec; v++) begin
      drive(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].mode, vecs[v].addr);
      stepCheck($sformatf("vec%0d", v), vecs[v].expShift, vecs[v].expGtr);
    end

    // T6: async reset during the second step of a 4SEQ starting at page 1
    drive(1'b0, 3'd0, 3'd0, 2'd3, 3'd1);
    stepCheck("abort_step1", 3'd1, 1'b0);
    drive(1'b0, 3'd0, 3'd0, 2'd0, 3'd0);
    stepCheck("abort_step2", 3'd2, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check("abort_async_clear", 3'd0, 1'b0);
    repeat (2) @(posedge sys_clk);
    #1;
    check("abort_in_reset", 3'd0, 1'b0);
    @(negedge sys_clk);
    rstn = 1'b1;
    // The aborted sequence must not resume: its final step would raise isGtr.
    drive(1'b0, 3'd0, 3'd0, 2'd0, 3'd0);
    stepCheck("post_reset_ready", 3'd0, 1'b0);
    drive(1'b1, 3'd3, 3'd5, 2'd0, 3'd0);
    stepCheck("post_reset_write", 3'd0, 1'b0);
    drive(1'b0, 3'd0, 3'd0, 2'd1, 3'd3);
    stepCheck("post_reset_1seq", 3'd5, 1'b1);
    drive(1'b0, 3'd0, 3'd0, 2'd1, 3'd1);
    stepCheck("post_reset_rf_cleared", 3'd0, 1'b1);
    drive(1'b0, 3'd0, 3'd0, 2'd0, 3'd0);
    stepCheck("post_reset_idle", 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
